// File: rtl/excp_commit.sv
// Exception/ERTN commit unit: takes retiring WB instructions, resolves trap priority,
// pulses csr_bus for one cycle and holds pipe_flush while the front-end redirects.
//
// state | meaning
// IDLE  | accepting WB instructions, no flush
// ISSUE | csr_bus carries the decoded trap, flush asserted
// DRAIN | flush held for DRAIN_CYCLES while the redirect settles
module excp_commit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CSR_BUS_WD   = 82
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [31:0]           wb_pc,
    input  logic [31:0]           wb_vaddr,
    input  logic [4:0]            wb_excp,
    input  logic                  wb_is_ertn,
    input  logic                  wb_csr_wen,
    input  logic                  have_intrpt,
    output logic [CSR_BUS_WD-1:0] csr_bus,
    output logic                  commit_csr_wen,
    output logic                  commit_valid,
    output logic                  pipe_flush,
    output logic [31:0]           excp_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam int IN_EXCP_BIT = CSR_BUS_WD - 2;

    state_t state, state_next;
    logic [3:0] drain_cnt;
    logic accept;
    logic trap;

    logic        dec_is_ertn;
    logic        dec_in_excp;
    logic [5:0]  dec_ecode;
    logic [31:0] dec_era;
    logic        dec_use_badv;
    logic [31:0] dec_badv;
    logic [CSR_BUS_WD-1:0] dec_bus;

    assign accept = wb_valid & (state == IDLE) & ~rst;
    assign trap   = have_intrpt | (|wb_excp) | wb_is_ertn;

    // wb_excp = {ale,brk,sys,ine,adef}; interrupt outranks all, ERTN only when nothing else fires
    always_comb begin
        dec_is_ertn  = 1'b0;
        dec_in_excp  = 1'b1;
        dec_ecode    = 6'h00;
        dec_era      = wb_pc;
        dec_use_badv = 1'b0;
        dec_badv     = 32'd0;
        if (have_intrpt) begin
            dec_ecode = 6'h00;
        end else if (wb_excp[0]) begin
            dec_ecode    = 6'h08;
            dec_use_badv = 1'b1;
            dec_badv     = wb_pc;
        end else if (wb_excp[1]) begin
            dec_ecode = 6'h0D;
        end else if (wb_excp[2]) begin
            dec_ecode = 6'h0B;
        end else if (wb_excp[3]) begin
            dec_ecode = 6'h0C;
        end else if (wb_excp[4]) begin
            dec_ecode    = 6'h09;
            dec_use_badv = 1'b1;
            dec_badv     = wb_vaddr;
        end else begin
            dec_is_ertn = wb_is_ertn;
            dec_in_excp = 1'b0;
            dec_era     = 32'd0;
        end
    end

    assign dec_bus = {dec_is_ertn, dec_in_excp, dec_ecode, 9'd0, dec_era, dec_use_badv, dec_badv};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && trap) state_next = ISSUE;
            ISSUE:   state_next = DRAIN;
            DRAIN:   if (drain_cnt == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wb_ready       = (state == IDLE) & ~rst;
        pipe_flush     = (state != IDLE);
        commit_valid   = accept & ~trap;
        commit_csr_wen = accept & ~trap & wb_csr_wen;
    end

    // csr_bus is nonzero only in the cycle after a trapping accept
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_bus <= '0;
        end else if (accept && trap) begin
            csr_bus <= dec_bus;
        end else begin
            csr_bus <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= 4'd0;
        end else if (state == ISSUE) begin
            drain_cnt <= DRAIN_LOAD;
        end else if (state == DRAIN && drain_cnt != 4'd0) begin
            drain_cnt <= drain_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            excp_count <= 32'd0;
        end else if (state == ISSUE && csr_bus[IN_EXCP_BIT]) begin
            excp_count <= excp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_excp_commit.sv
// Self-checking bench for excp_commit: scoreboard of expected csr_bus pulses
// plus per-scenario checks of commit strobes, flush length and counters.
module tb_excp_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [4:0]  wb_excp;
    logic        wb_is_ertn;
    logic        wb_csr_wen;
    logic        have_intrpt;
    logic [81:0] csr_bus;
    logic        commit_csr_wen;
    logic        commit_valid;
    logic        pipe_flush;
    logic [31:0] excp_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [81:0] prev_bus = '0;
    logic [81:0] sb_q[$];
    logic [31:0] exp_count = 32'd0;

    excp_commit #(.DRAIN_CYCLES(3), .CSR_BUS_WD(82)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_excp(wb_excp),
        .wb_is_ertn(wb_is_ertn), .wb_csr_wen(wb_csr_wen), .have_intrpt(have_intrpt),
        .csr_bus(csr_bus), .commit_csr_wen(commit_csr_wen), .commit_valid(commit_valid),
        .pipe_flush(pipe_flush), .excp_count(excp_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected bus: {is_etrn,in_excp,ecode,esubcode,era,use_badv,badv}, wb_excp = {ale,brk,sys,ine,adef}
    function automatic logic [81:0] exp_bus(input logic intr, input logic [4:0] ex, input logic ertn,
                                            input logic [31:0] pc, input logic [31:0] va);
        if (intr)       return {1'b0, 1'b1, 6'h00, 9'd0, pc, 1'b0, 32'd0};
        else if (ex[0]) return {1'b0, 1'b1, 6'h08, 9'd0, pc, 1'b1, pc};
        else if (ex[1]) return {1'b0, 1'b1, 6'h0D, 9'd0, pc, 1'b0, 32'd0};
        else if (ex[2]) return {1'b0, 1'b1, 6'h0B, 9'd0, pc, 1'b0, 32'd0};
        else if (ex[3]) return {1'b0, 1'b1, 6'h0C, 9'd0, pc, 1'b0, 32'd0};
        else if (ex[4]) return {1'b0, 1'b1, 6'h09, 9'd0, pc, 1'b1, va};
        else if (ertn)  return {1'b1, 1'b0, 80'd0};
        return '0;
    endfunction

    // Scoreboard monitor: every nonzero csr_bus cycle must match the oldest expected trap
    always @(negedge clk) begin
        if (mon_en && csr_bus !== '0) begin
            checks++;
            if (prev_bus !== '0) begin
                errors++;
                $display("FAIL pulse_width: csr_bus nonzero two cycles running, got %h after %h", csr_bus, prev_bus);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %h expected no pulse", csr_bus);
            end else begin
                logic [81:0] e;
                e = sb_q.pop_front();
                if (csr_bus !== e) begin
                    errors++;
                    $display("FAIL csr_bus: got %h expected %h", csr_bus, e);
                end
            end
        end
        prev_bus = csr_bus;
    end

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = 32'd0; wb_vaddr = 32'd0; wb_excp = 5'd0;
        wb_is_ertn = 1'b0; wb_csr_wen = 1'b0; have_intrpt = 1'b0;
    endtask

    task automatic present(input logic intr, input logic [4:0] ex, input logic ertn, input logic cw,
                           input logic [31:0] pc, input logic [31:0] va);
        wb_valid = 1'b1; have_intrpt = intr; wb_excp = ex; wb_is_ertn = ertn;
        wb_csr_wen = cw; wb_pc = pc; wb_vaddr = va;
        if (intr | (|ex) | ertn) sb_q.push_back(exp_bus(intr, ex, ertn, pc, va));
    endtask

    // Counts flush cycles starting at the current negedge; bounded so a stuck flush cannot hang
    task automatic wait_idle(output int fl, output int nr);
        fl = 0; nr = 0;
        for (int i = 0; i < 20 && pipe_flush; i++) begin
            fl++;
            if (!wb_ready) nr++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        @(negedge clk); @(negedge clk);
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", wb_ready); end
        checks++; if (csr_bus !== '0) begin errors++; $display("FAIL reset_bus: got %h expected 0", csr_bus); end
        checks++; if (pipe_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", pipe_flush); end
        checks++; if (excp_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", excp_count); end
        checks++; if (commit_valid !== 1'b0 || commit_csr_wen !== 1'b0) begin
            errors++; $display("FAIL reset_commit: got %b%b expected 00", commit_valid, commit_csr_wen); end
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", wb_ready); end
    endtask

    task automatic test_no_trap();
        @(negedge clk);
        present(1'b0, 5'd0, 1'b0, 1'b1, 32'h1C00_0040, 32'd0);
        #1;
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL notrap_valid: got %b expected 1", commit_valid); end
        checks++; if (commit_csr_wen !== 1'b1) begin errors++; $display("FAIL notrap_wen: got %b expected 1", commit_csr_wen); end
        @(negedge clk);
        idle_inputs();
        checks++; if (wb_ready !== 1'b1 || pipe_flush !== 1'b0) begin
            errors++; $display("FAIL notrap_after: got ready=%b flush=%b expected ready=1 flush=0", wb_ready, pipe_flush); end
        checks++; if (csr_bus !== '0) begin errors++; $display("FAIL notrap_bus: got %h expected 0", csr_bus); end
    endtask

    // One accepted trap end to end; returns flush/ready-low lengths for the caller to check
    task automatic run_trap(input logic intr, input logic [4:0] ex, input logic ertn,
                            input logic [31:0] pc, input logic [31:0] va, output int fl, output int nr);
        @(negedge clk);
        present(intr, ex, ertn, 1'b1, pc, va);
        #1;
        checks++; if (commit_csr_wen !== 1'b0 || commit_valid !== 1'b0 || wb_ready !== 1'b1) begin
            errors++; $display("FAIL trap_accept: got wen=%b valid=%b ready=%b expected 0 0 1",
                               commit_csr_wen, commit_valid, wb_ready); end
        @(negedge clk);
        idle_inputs();
        wait_idle(fl, nr);
        if (intr | (|ex)) exp_count = exp_count + 32'd1;
    endtask

    task automatic test_sys();
        int fl, nr;
        run_trap(1'b0, 5'b00100, 1'b0, 32'h1C00_0100, 32'd0, fl, nr);
        checks++; if (fl != 4) begin errors++; $display("FAIL sys_flush_len: got %0d expected 4", fl); end
        checks++; if (nr != 4) begin errors++; $display("FAIL sys_ready_low: got %0d expected 4", nr); end
        checks++; if (excp_count !== exp_count) begin errors++; $display("FAIL sys_count: got %0d expected %0d", excp_count, exp_count); end
    endtask

    task automatic test_priority();
        int fl, nr;
        run_trap(1'b0, 5'b10001, 1'b0, 32'h1C00_0003, 32'h8000_0002, fl, nr);
        run_trap(1'b0, 5'b10000, 1'b0, 32'h1C00_0003, 32'h8000_0002, fl, nr);
        for (int b = 0; b < 5; b++) begin
            run_trap(1'b0, 5'(1 << b), 1'b0, $urandom, $urandom, fl, nr);
            checks++; if (fl != 4) begin errors++; $display("FAIL flag%0d_flush_len: got %0d expected 4", b, fl); end
        end
        checks++; if (excp_count !== exp_count) begin errors++; $display("FAIL prio_count: got %0d expected %0d", excp_count, exp_count); end
    endtask

    task automatic test_intr_ertn();
        int fl, nr;
        run_trap(1'b1, 5'd0, 1'b1, 32'h1C00_0200, 32'd0, fl, nr);
        checks++; if (excp_count !== exp_count) begin errors++; $display("FAIL intr_count: got %0d expected %0d", excp_count, exp_count); end
        run_trap(1'b0, 5'd0, 1'b1, 32'h1C00_0300, 32'd0, fl, nr);
        checks++; if (fl != 4) begin errors++; $display("FAIL ertn_flush_len: got %0d expected 4", fl); end
        checks++; if (excp_count !== exp_count) begin errors++; $display("FAIL ertn_count: got %0d expected %0d", excp_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, n, fl, nr;
        logic [31:0] base;
        base = excp_count;
        @(negedge clk);
        present(1'b0, 5'b00010, 1'b0, 1'b0, 32'h1C00_0400, 32'd0);
        #1;
        t0 = cyc;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b expected 1", wb_ready); end
        @(negedge clk);
        present(1'b0, 5'b01000, 1'b0, 1'b0, 32'h1C00_0500, 32'd0);
        n = 0;
        while (!wb_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        checks++; if (t1 - t0 != 5) begin errors++; $display("FAIL b2b_gap: got %0d expected 5", t1 - t0); end
        @(negedge clk);
        idle_inputs();
        wait_idle(fl, nr);
        exp_count = exp_count + 32'd2;
        checks++; if (excp_count - base !== 32'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", excp_count - base); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_reset_in_drain();
        @(negedge clk);
        present(1'b0, 5'b00100, 1'b0, 1'b0, 32'h1C00_0600, 32'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++; if (pipe_flush !== 1'b1) begin errors++; $display("FAIL drain2_flush: got %b expected 1", pipe_flush); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (pipe_flush !== 1'b0) begin errors++; $display("FAIL rst_drain_flush: got %b expected 0", pipe_flush); end
        checks++; if (excp_count !== 32'd0) begin errors++; $display("FAIL rst_drain_count: got %0d expected 0", excp_count); end
        checks++; if (csr_bus !== '0) begin errors++; $display("FAIL rst_drain_bus: got %h expected 0", csr_bus); end
        rst = 1'b0;
        exp_count = 32'd0;
        @(negedge clk);
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rst_drain_ready: got %b expected 1", wb_ready); end
    endtask

    initial begin
        test_reset();
        test_no_trap();
        test_sys();
        test_priority();
        test_intr_ertn();
        test_back_to_back();
        test_reset_in_drain();
        repeat (3) @(negedge clk);
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/excp_commit.md
Name: excp_commit

Overview:
- Exception/ERTN commit unit between the writeback stage and the CSR file.
- Accepts one retiring instruction per cycle from WB with valid/ready, applies exception priority and samples pending interrupts.
- Drives the CSR file's `csr_bus` as a registered one-cycle pulse, then holds a pipeline flush while the front-end redirects.
- Suppresses CSR writes and normal retirement for any instruction that traps.

Parameters:
- DRAIN_CYCLES, 3: cycles `pipe_flush` stays high in DRAIN after the pulse; legal range 1..15.
- CSR_BUS_WD, 82: width of `csr_bus`; fixed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  WB holds a retiring instruction
- wb_ready  out  1  unit accepts WB instruction this cycle
- wb_pc  in  32  PC of WB instruction
- wb_vaddr  in  32  memory address (for ALE)
- wb_excp  in  5  {ale,brk,sys,ine,adef} flags from earlier stages
- wb_is_ertn  in  1  instruction is ERTN
- wb_csr_wen  in  1  instruction writes a CSR
- have_intrpt  in  1  pending enabled interrupt from CSR file
- csr_bus  out  82  {is_etrn,in_excp,ecode[5:0],esubcode[8:0],era[31:0],use_badv,badv[31:0]}
- commit_csr_wen  out  1  qualified CSR write enable to CSR file
- commit_valid  out  1  pulse: instruction retired without trap
- pipe_flush  out  1  kill all younger in-flight instructions
- excp_count  out  32  count of issued exceptions and interrupts (ERTN excluded)

Behaviour:
- Reset: state=IDLE. `csr_bus`=0, `wb_ready`=0 during the reset cycle. `commit_csr_wen`=0, `commit_valid`=0, `pipe_flush`=0, `excp_count`=0.
- `wb_ready` = (state==IDLE) & ~rst. Accept = `wb_valid` & `wb_ready`.
- Trap condition on accept: `have_intrpt` | (|`wb_excp`) | `wb_is_ertn`.
- Priority, highest first, with ecode/esubcode, `use_badv`, `badv`:
  - INT 0x00/0, use_badv=0
  - ADEF 0x08/0, use_badv=1, badv=`wb_pc`
  - INE 0x0D/0, use_badv=0
  - SYS 0x0B/0, use_badv=0
  - BRK 0x0C/0, use_badv=0
  - ALE 0x09/0, use_badv=1, badv=`wb_vaddr`
  - ERTN: is_etrn=1, in_excp=0, all other fields 0
- `era` = `wb_pc` for every exception and interrupt. An interrupt is taken on the accepted instruction, which does not retire.
- Accepted, no trap:
  - Combinational in the accept cycle: `commit_valid`=1, `commit_csr_wen`=`wb_csr_wen`.
  - State stays IDLE.
- Accepted, trap:
  - Combinational in the accept cycle: `commit_valid`=0, `commit_csr_wen`=0. This guarantees the CSR file never sees a write and an exception together.
  - Registered `csr_bus` loads on the accept edge. State goes to ISSUE.
- ISSUE (exactly 1 cycle):
  - `csr_bus` holds the decoded value; `pipe_flush`=1; `wb_ready`=0.
  - `excp_count` increments by 1 at the end of the cycle if in_excp=1 (wraps at 2^32).
  - Next state DRAIN; counter loads DRAIN_CYCLES-1.
- DRAIN:
  - `csr_bus`=0, `pipe_flush`=1, `wb_ready`=0.
  - Counter decrements; at 0, next state IDLE.
  - Total flush length = 1+DRAIN_CYCLES cycles.
- IDLE: `csr_bus`=0 and `pipe_flush`=0 every cycle. `csr_bus` is never nonzero for more than one cycle per trap.
- `wb_ready`=0 is a backpressure stall, not a kill. Instructions presented while in ISSUE/DRAIN are not accepted. WB is flushed by `pipe_flush` anyway.
- `have_intrpt` is sampled only at accept. An interrupt arriving during ISSUE/DRAIN waits for the next accepted instruction.
- `wb_is_ertn` together with any exception flag or interrupt: the exception wins and `is_etrn`=0.
- Reset mid-ISSUE/DRAIN: immediate return to IDLE. All outputs take reset values on the next edge; no partial pulse is retained.
- `commit_valid` and `commit_csr_wen` are combinational from accept. `csr_bus`, `pipe_flush` and `excp_count` are registered/state-decoded.

Test Plan:
- No-trap retire: `wb_valid`=1, `wb_excp`=0, `wb_csr_wen`=1, `have_intrpt`=0 → same cycle `commit_valid`=1, `commit_csr_wen`=1. `csr_bus` stays 0; `wb_ready` stays 1 the next cycle.
- SYS trap: `wb_pc`=0x1C000100, `wb_excp`=sys, `wb_csr_wen`=1 →
  - accept cycle: `commit_csr_wen`=0.
  - next cycle: `csr_bus` in_excp=1, ecode=0x0B, era=0x1C000100, use_badv=0.
  - `pipe_flush` high 4 cycles (DRAIN_CYCLES=3); `excp_count`=1; `wb_ready` low 4 cycles.
- Priority: `wb_excp`={ale=1,adef=1}, `wb_pc`=0x1C000003, `wb_vaddr`=0x8000_0002 → ecode=0x08, badv=0x1C000003. The same with only ale set → ecode=0x09, badv=0x8000_0002.
- Interrupt over ERTN: `have_intrpt`=1, `wb_is_ertn`=1 → in_excp=1, is_etrn=0, ecode=0x00, era=`wb_pc`. Repeat with `have_intrpt`=0 → is_etrn=1, in_excp=0, `excp_count` unchanged.
- Back-to-back: trap, then `wb_valid` held high with a second trap → second accept exactly 5 cycles after the first. Two distinct single-cycle `csr_bus` pulses; `excp_count`=2.
- Reset in DRAIN: assert `rst` in DRAIN cycle 2 → next cycle `pipe_flush`=0, `excp_count`=0, `csr_bus`=0. After `rst` deasserts, `wb_ready`=1 the following cycle.
